// File: rtl/decode_stage_pipe_pkg.sv
// Shared types and constants for the decode stage: instruction layout,
// supported opcodes and the R-type function codes.
package decode_stage_pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic [5:0] op_code;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] func;
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LTYPE = 6'h23;
  localparam logic [5:0] OP_STYPE = 6'h2B;

  typedef enum logic [5:0] {
    FUNC_ADD = 6'h20,
    FUNC_SUB = 6'h22,
    FUNC_AND = 6'h24,
    FUNC_OR  = 6'h25,
    FUNC_SLT = 6'h2A
  } func_e;

  // The immediate overlays rd/shamt/func in the low half of the word.
  function automatic logic [15:0] imm_of(instr_t ins);
    return {ins.rd, ins.shamt, ins.func};
  endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile.sv
// Two-read, one-write register file. Register 0 is hard-wired to zero and
// reads see a same-cycle write (write-through bypass).
module decode_stage_pipe_regfile #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic             wr_act;

  assign wr_act = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_act) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
    if (wr_act && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (wr_act && waddr_i == raddr2_i) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file read, instruction decode and the ID/EX
// pipeline register with load-use stall, bubble insertion and flush.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [31:0]      instr,
  output logic             inReady,
  input  logic             flush,
  input  logic             wbRegWrite,
  input  logic             wbMemToReg,
  input  logic [AW-1:0]    wbAddr,
  input  logic [WIDTH-1:0] wbAluResult,
  input  logic [WIDTH-1:0] wbReadMemData,
  input  logic             outReady,
  output logic             outValid,
  output logic [WIDTH-1:0] readRegData1,
  output logic [WIDTH-1:0] readRegData2,
  output logic [WIDTH-1:0] signExtend,
  output logic [AW-1:0]    destReg,
  output logic [5:0]       func,
  output logic             regWrite,
  output logic             memToReg,
  output logic             memWrite,
  output logic             aluSrc,
  output logic             illegal
);

  instr_t           ins;
  logic [AW-1:0]    rs_a, rt_a, rd_a;
  logic [WIDTH-1:0] wb_data, rd1_d, rd2_d, sext_d;
  logic [AW-1:0]    dest_d;
  logic             reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, illegal_d, uses_rt_d;
  logic             advance, hazard;

  logic             valid_q, reg_write_q, mem_to_reg_q, mem_write_q, alu_src_q, illegal_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, sext_q;
  logic [AW-1:0]    dest_q;
  logic [5:0]       func_q;

  assign ins     = instr_t'(instr);
  assign rs_a    = ins.rs[AW-1:0];
  assign rt_a    = ins.rt[AW-1:0];
  assign rd_a    = ins.rd[AW-1:0];
  assign wb_data = wbMemToReg ? wbReadMemData : wbAluResult;
  assign sext_d  = WIDTH'(signed'(imm_of(ins)));

  decode_stage_pipe_regfile #(.NREGS(NREGS), .WIDTH(WIDTH)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wbRegWrite),
    .waddr_i (wbAddr),
    .wdata_i (wb_data),
    .raddr1_i(rs_a),
    .raddr2_i(rt_a),
    .rdata1_o(rd1_d),
    .rdata2_o(rd2_d)
  );

  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    illegal_d    = 1'b0;
    uses_rt_d    = 1'b0;
    dest_d       = '0;
    case (ins.op_code)
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        uses_rt_d   = 1'b1;
        dest_d      = rd_a;
      end
      OP_LTYPE: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
        dest_d       = rt_a;
      end
      OP_STYPE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        uses_rt_d   = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Handshake: an instruction transfers on a rising edge where valid and
  // ready are both high; valid never depends on ready. ID/EX may move on
  // when it is empty or the execute stage takes its contents this edge.
  assign advance = outReady || !valid_q;
  assign hazard  = valid_q && mem_to_reg_q && (dest_q != '0) &&
                   ((dest_q == rs_a) || (uses_rt_d && dest_q == rt_a));
  assign inReady = advance && !hazard && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      sext_q       <= '0;
      dest_q       <= '0;
      func_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (flush || (advance && hazard)) begin
      // Bubble: data fields are left as they were, only validity and controls drop.
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (advance) begin
      valid_q      <= inValid;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      sext_q       <= sext_d;
      dest_q       <= dest_d;
      func_q       <= ins.func;
      reg_write_q  <= reg_write_d && inValid;
      mem_to_reg_q <= mem_to_reg_d && inValid;
      mem_write_q  <= mem_write_d && inValid;
      alu_src_q    <= alu_src_d && inValid;
      illegal_q    <= illegal_d && inValid;
    end
  end

  assign outValid     = valid_q;
  assign readRegData1 = rd1_q;
  assign readRegData2 = rd2_q;
  assign signExtend   = sext_q;
  assign destReg      = dest_q;
  assign func         = func_q;
  assign regWrite     = reg_write_q;
  assign memToReg     = mem_to_reg_q;
  assign memWrite     = mem_write_q;
  assign aluSrc       = alu_src_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus a random phase, with a
// register-file model and an expected queue for the ID/EX contents.
module tb_decode_stage_pipe;
  import decode_stage_pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int EW    = 3 * WIDTH + AW + 6 + 5;

  logic             clk, rst, inValid, inReady, flush;
  logic [31:0]      instr;
  logic             wbRegWrite, wbMemToReg;
  logic [AW-1:0]    wbAddr;
  logic [WIDTH-1:0] wbAluResult, wbReadMemData;
  logic             outReady, outValid;
  logic [WIDTH-1:0] readRegData1, readRegData2, signExtend;
  logic [AW-1:0]    destReg;
  logic [5:0]       func;
  logic             regWrite, memToReg, memWrite, aluSrc, illegal;

  decode_stage_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .instr(instr), .inReady(inReady),
    .flush(flush), .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg),
    .wbAddr(wbAddr), .wbAluResult(wbAluResult), .wbReadMemData(wbReadMemData),
    .outReady(outReady), .outValid(outValid), .readRegData1(readRegData1),
    .readRegData2(readRegData2), .signExtend(signExtend), .destReg(destReg),
    .func(func), .regWrite(regWrite), .memToReg(memToReg), .memWrite(memWrite),
    .aluSrc(aluSrc), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state and scoreboard ----------------
  logic [WIDTH-1:0] reg_m [NREGS];
  logic [EW-1:0]    exp_q [$];
  logic             m_valid = 1'b0, m_mtr = 1'b0;
  logic [AW-1:0]    m_dest = '0;
  logic             rst_p;
  logic             p_we, p_mtr;
  logic [AW-1:0]    p_addr;
  logic [WIDTH-1:0] p_alu, p_mem;
  logic [WIDTH-1:0] wb_model;
  int               n_checks = 0, n_fail = 0;

  assign wb_model = wbMemToReg ? wbReadMemData : wbAluResult;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] build_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] build_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic void bdecode(input logic [5:0] op, output logic rw, output logic mtr,
                                  output logic mw, output logic as, output logic ill,
                                  output logic ut);
    rw = 0; mtr = 0; mw = 0; as = 0; ill = 0; ut = 0;
    if (op == 6'h00) begin rw = 1; ut = 1; end
    else if (op == 6'h23) begin rw = 1; mtr = 1; as = 1; end
    else if (op == 6'h2B) begin mw = 1; as = 1; ut = 1; end
    else ill = 1;
  endfunction

  function automatic logic [AW-1:0] bdest(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) return ins[15:11];
    if (ins[31:26] == 6'h23) return ins[20:16];
    return '0;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (wbRegWrite && wbAddr == a) return wb_model;
    return reg_m[a];
  endfunction

  function automatic logic [EW-1:0] expect_of(input logic [31:0] ins);
    logic rw, mtr, mw, as, ill, ut;
    bdecode(ins[31:26], rw, mtr, mw, as, ill, ut);
    return {model_read(ins[25:21]), model_read(ins[20:16]), {{16{ins[15]}}, ins[15:0]},
            bdest(ins), ins[5:0], rw, mtr, mw, as, ill};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                      input logic ordy, output logic acc);
    logic adv, haz, rw, mtr, mw, as, ill, ut, exp_rdy;
    logic [EW-1:0] got;
    @(negedge clk);
    rst = rst_p; inValid = iv; instr = ins; flush = fl; outReady = ordy;
    wbRegWrite = p_we; wbMemToReg = p_mtr; wbAddr = p_addr;
    wbAluResult = p_alu; wbReadMemData = p_mem;
    p_we = 1'b0;
    #1;
    bdecode(ins[31:26], rw, mtr, mw, as, ill, ut);
    adv = ordy || !m_valid;
    haz = m_valid && m_mtr && (m_dest != 0) &&
          ((m_dest == ins[25:21]) || (ut && m_dest == ins[20:16]));
    exp_rdy = adv && !haz && !fl && !rst_p;
    check("in_ready", inReady, exp_rdy);
    check("out_valid", outValid, m_valid);
    if (outValid) begin
      got = {readRegData1, readRegData2, signExtend, destReg, func,
             regWrite, memToReg, memWrite, aluSrc, illegal};
      check("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("idex", got, exp_q[0]);
        if (ordy || fl) void'(exp_q.pop_front());
      end
    end
    acc = iv && inReady;
    if (acc) exp_q.push_back(expect_of(ins));
    @(posedge clk);
    if (rst_p) begin
      for (int i = 0; i < NREGS; i++) reg_m[i] = '0;
      exp_q.delete();
      m_valid = 0; m_mtr = 0; m_dest = '0;
    end else begin
      if (wbRegWrite && wbAddr != 0) reg_m[wbAddr] = wb_model;
      if (fl || (adv && haz)) begin
        m_valid = 0; m_mtr = 0;
      end else if (adv) begin
        m_valid = iv; m_mtr = iv && mtr; m_dest = bdest(ins);
      end
    end
  endtask

  task automatic set_wb(input logic mtr, input logic [AW-1:0] addr,
                        input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] mem);
    p_we = 1'b1; p_mtr = mtr; p_addr = addr; p_alu = alu; p_mem = mem;
  endtask

  task automatic issue(input logic [31:0] ins, output int tries);
    logic acc;
    acc = 0; tries = 0;
    while (!acc && tries < 20) begin
      step(1'b1, ins, 1'b0, 1'b1, acc);
      tries++;
    end
    check("issue_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tries;
    logic acc;
    logic [5:0] op;
    logic [EW-1:0] got0;
    rst = 1; inValid = 0; instr = '0; flush = 0; outReady = 0;
    wbRegWrite = 0; wbMemToReg = 0; wbAddr = '0; wbAluResult = '0; wbReadMemData = '0;
    p_we = 0; p_mtr = 0; p_addr = '0; p_alu = '0; p_mem = '0;
    for (int i = 0; i < NREGS; i++) reg_m[i] = '0;

    // Reset held with a valid instruction presented
    rst_p = 1;
    for (int i = 0; i < 3; i++) step(1'b1, build_r(5'd1, 5'd2, 5'd3, FUNC_ADD), 1'b0, 1'b1, acc);
    #1;
    got0 = {readRegData1, readRegData2, signExtend, destReg, func,
            regWrite, memToReg, memWrite, aluSrc, illegal};
    check("reset_idex", got0, '0);
    rst_p = 0;

    // All registers read zero after reset
    for (int i = 1; i < 32; i++) issue(build_r(5'(i), 5'((i % 31) + 1), 5'(i), FUNC_ADD), tries);
    idle(2);

    // Writeback bypass into the same-cycle read, then memToReg writeback
    set_wb(1'b0, 5'd1, 32'h99, 32'h1234);
    issue(build_r(5'd1, 5'd2, 5'd3, FUNC_ADD), tries);
    check("bypass_tries", tries, 1);
    set_wb(1'b1, 5'd2, 32'h77, 32'h55);
    idle(1);
    issue(build_r(5'd2, 5'd1, 5'd5, FUNC_SUB), tries);

    // Register 0 ignores writes
    set_wb(1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(build_r(5'd0, 5'd0, 5'd6, FUNC_OR), tries);
    issue(build_r(5'd0, 5'd2, 5'd6, FUNC_OR), tries);

    // Sign extension: negative sType and positive lType immediates
    issue(build_i(OP_STYPE, 5'd1, 5'd2, 16'h8005), tries);
    issue(build_i(OP_LTYPE, 5'd1, 5'd7, 16'h0005), tries);
    idle(2);

    // Load-use stall costs one cycle; unrelated sType does not stall
    issue(build_i(OP_LTYPE, 5'd1, 5'd4, 16'h0010), tries);
    issue(build_r(5'd4, 5'd0, 5'd8, FUNC_ADD), tries);
    check("load_use_tries", tries, 2);
    issue(build_i(OP_LTYPE, 5'd1, 5'd4, 16'h0010), tries);
    issue(build_i(OP_STYPE, 5'd6, 5'd5, 16'h0004), tries);
    check("no_stall_tries", tries, 1);
    issue(build_i(OP_LTYPE, 5'd1, 5'd4, 16'h0010), tries);
    issue(build_i(OP_STYPE, 5'd6, 5'd4, 16'h0004), tries);
    check("store_rt_stall_tries", tries, 2);
    issue(build_i(OP_LTYPE, 5'd1, 5'd0, 16'h0010), tries);
    issue(build_r(5'd0, 5'd0, 5'd9, FUNC_AND), tries);
    check("r0_no_stall_tries", tries, 1);
    idle(2);

    // Backpressure holds ID/EX, flush refuses input, illegal opcode flows
    issue(build_r(5'd1, 5'd2, 5'd10, FUNC_SLT), tries);
    for (int i = 0; i < 3; i++) step(1'b1, build_r(5'd3, 5'd4, 5'd11, FUNC_ADD), 1'b0, 1'b0, acc);
    step(1'b1, build_r(5'd3, 5'd4, 5'd11, FUNC_ADD), 1'b1, 1'b1, acc);
    check("flush_not_taken", acc, 0);
    idle(1);
    issue(build_i(6'h3F, 5'd1, 5'd2, 16'hABCD), tries);
    idle(1);

    // Reset in the middle of a stall discards the held instruction
    issue(build_r(5'd2, 5'd3, 5'd12, FUNC_ADD), tries);
    step(1'b1, build_r(5'd1, 5'd1, 5'd13, FUNC_ADD), 1'b0, 1'b0, acc);
    rst_p = 1;
    step(1'b1, build_r(5'd1, 5'd1, 5'd13, FUNC_ADD), 1'b0, 1'b0, acc);
    rst_p = 0;
    idle(2);

    // Random traffic with hazards, backpressure, flushes and writebacks
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: op = OP_RTYPE;
        1: op = OP_LTYPE;
        2: op = OP_STYPE;
        3: op = 6'h3F;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1)
        set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom);
      step(($urandom_range(0, 3) != 0),
           build_i(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   {5'($urandom_range(0, 7)), 11'($urandom)}),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), acc);
    end
    idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised successor to the single-cycle decode block. It holds the NREGS x WIDTH register file and the writeback mux (memToReg), and decodes the instruction fields, control signals and sign-extended immediate. Results are registered into an ID/EX pipeline register under a valid/ready handshake. Adds write-through bypass, load-use hazard stall with bubble insertion, and flush; sits between the fetch stage and the execute stage.

Parameters:
WIDTH, 32, datapath/register width (>=16)
NREGS, 32, number of architectural registers (power of 2, <=32)
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
inValid  in  1  fetch presents a valid instr
instr  in  32  instrType: opCode[31:26] rs[25:21] rt[20:16] rd[15:11] func[5:0] imm[15:0]
inReady  out  1  instr accepted this cycle when inValid&&inReady
flush  in  1  kill ID/EX contents and refuse input this cycle
wbRegWrite  in  1  writeback enable
wbMemToReg  in  1  1: write wbReadMemData, 0: write wbAluResult
wbAddr  in  AW  writeback destination register
wbAluResult  in  WIDTH  ALU result from writeback stage
wbReadMemData  in  WIDTH  load data from writeback stage
outReady  in  1  execute stage can accept
outValid  out  1  ID/EX holds a valid instruction
readRegData1  out  WIDTH  rs operand
readRegData2  out  WIDTH  rt operand
signExtend  out  WIDTH  sign-extended imm
destReg  out  AW  rd for rType, rt for lType, 0 otherwise
func  out  6  func field (valid for rType)
regWrite, memToReg, memWrite, aluSrc  out  1 each  EX/MEM/WB controls
illegal  out  1  unrecognised opCode

Behaviour:
- Reset (rst=1 at posedge): all registers 0, outValid=0, every ID/EX output 0. Reset mid-stall discards the held instruction. inReady=0 while rst=1.
- Register file: reg 0 always reads 0 and is never written. Write happens at posedge when wbRegWrite && wbAddr!=0. wbData = wbMemToReg ? wbReadMemData : wbAluResult.
- Read is combinational with write-through: if wbRegWrite && wbAddr!=0 && wbAddr==rs, the rs operand equals wbData in the same cycle (same rule for rt).
- Decode: rType(6'h00) gives regWrite=1, aluSrc=0, destReg=rd, uses rs and rt. lType(6'h23) gives regWrite=1, memToReg=1, aluSrc=1, destReg=rt, uses rs only. sType(6'h2B) gives memWrite=1, aluSrc=1, destReg=0, uses rs and rt. Any other opcode: all controls 0, destReg=0, illegal=1; it still flows with outValid=1.
- signExtend = {{(WIDTH-16){imm[15]}}, imm[15:0]}.
- advance = outReady || !outValid.
- hazard = outValid && memToReg && destReg!=0 && (destReg==rs || (usesRt && destReg==rt)) for the incoming instr.
- inReady = advance && !hazard && !flush && !rst.
- Each posedge, in priority order:
  1. rst: reset.
  2. flush: outValid<=0, controls<=0.
  3. advance && hazard: bubble inserted (outValid<=0, controls<=0), instr not consumed.
  4. advance: ID/EX <= decoded instr, outValid<=inValid. Controls are forced to 0 when inValid=0.
  5. otherwise (!advance): ID/EX holds all values.
- Latency: 1 cycle from accept to outValid. Load-use costs exactly 1 bubble when outReady=1.
- Throughput: 1 instr/cycle with no hazard and outReady=1.
- Simultaneous writeback and read of the same register: bypass value is captured. Writeback continues during stall and flush.

Decomposition:
- Package def: instrType struct, opCode constants rType/lType/sType, func enum (ADD, ...), `width.
- Sub-module regfile (NREGS, WIDTH): 2 read ports, 1 write port, bypass and reg-0 rule.
- Decode logic, hazard logic and the ID/EX register stay in decode_stage_pipe.

Test Plan:
- Reset: hold rst 3 cycles with inValid=1 -> outValid=0 and inReady=0 throughout. After release, reading r1..r31 gives 0.
- Writeback and bypass: wbRegWrite=1, wbAddr=1, wbAluResult=32'h99, wbMemToReg=0, same cycle as rType rs=1 rt=2 rd=3 ADD -> next cycle readRegData1=32'h99, readRegData2=0, destReg=3, regWrite=1. Writeback with wbMemToReg=1, wbReadMemData=32'h55 to r2 -> later reads of r2 give 32'h55.
- Reg 0: write 32'hFFFF_FFFF to wbAddr=0 -> rs=0 reads 0.
- Sign extend and sType: imm=16'h8005 -> signExtend=32'hFFFF_8005, memWrite=1, regWrite=0, destReg=0. imm=16'h5 -> 32'h0000_0005.
- Load-use: lType rt=4 followed by rType rs=4, outReady=1 -> inReady=0 for one cycle, one outValid=0 bubble, then the rType is issued. lType rt=4 followed by sType rt=5 rs=6 -> no stall.
- Backpressure and flush: outReady=0 for 3 cycles -> ID/EX outputs stable and inReady=0. flush=1 with inValid=1 -> next cycle outValid=0 and the instruction is not consumed. Opcode 6'h3F -> illegal=1, regWrite=0.
